// File: rtl/udp_demux_pkg.sv
// Shared types for the UDP receive-side port demultiplexer.
package udp_demux_pkg;

  localparam int UDP_PORT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DROP
  } demux_state_t;

  // UDP RX header as delivered by the IP/UDP stack.
  typedef struct packed {
    logic [31:0]               ip_source_ip;
    logic [31:0]               ip_dest_ip;
    logic [UDP_PORT_WIDTH-1:0] source_port;
    logic [UDP_PORT_WIDTH-1:0] dest_port;
    logic [15:0]               length;
    logic [15:0]               checksum;
  } udp_hdr_t;

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority lookup of a destination port in the runtime port
// table; the lowest enabled matching entry wins.
module udp_port_match
  import udp_demux_pkg::*;
#(
  parameter int M_COUNT   = 2,
  parameter int SEL_WIDTH = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic [UDP_PORT_WIDTH-1:0]              dest_port,
  input  logic [M_COUNT-1:0][UDP_PORT_WIDTH-1:0] match_port,
  input  logic [M_COUNT-1:0]                     match_enable,
  output logic                                   hit,
  output logic [SEL_WIDTH-1:0]                   index
);

  logic [M_COUNT-1:0] eq;

  for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_cmp
    assign eq[gi] = match_enable[gi] && (match_port[gi] == dest_port);
  end

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    hit   = |eq;
    index = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (eq[i]) index = SEL_WIDTH'(i);
    end
  end

endmodule

// File: rtl/udp_port_demux.sv
// Steers each UDP RX packet (header + payload) to one of M_COUNT application
// channels selected by destination port; unmatched packets are consumed and
// counted. Header is registered, payload is a zero-latency pass-through.
module udp_port_demux
  import udp_demux_pkg::*;
#(
  parameter int M_COUNT    = 2,
  parameter int SEL_WIDTH  = (M_COUNT > 1) ? $clog2(M_COUNT) : 1,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  // incoming header
  input  logic                                   rx_hdr_valid,
  output logic                                   rx_hdr_ready,
  input  udp_hdr_t                               rx_hdr,
  // incoming payload
  input  logic [DATA_WIDTH-1:0]                  rx_tdata,
  input  logic [KEEP_WIDTH-1:0]                  rx_tkeep,
  input  logic                                   rx_tvalid,
  output logic                                   rx_tready,
  input  logic                                   rx_tlast,
  input  logic [ID_WIDTH-1:0]                    rx_tid,
  input  logic [DEST_WIDTH-1:0]                  rx_tdest,
  input  logic [USER_WIDTH-1:0]                  rx_tuser,
  // per-channel header
  output logic [M_COUNT-1:0]                     ch_hdr_valid,
  input  logic [M_COUNT-1:0]                     ch_hdr_ready,
  output udp_hdr_t [M_COUNT-1:0]                 ch_hdr,
  // per-channel payload
  output logic [M_COUNT-1:0][DATA_WIDTH-1:0]     ch_tdata,
  output logic [M_COUNT-1:0][KEEP_WIDTH-1:0]     ch_tkeep,
  output logic [M_COUNT-1:0]                     ch_tvalid,
  input  logic [M_COUNT-1:0]                     ch_tready,
  output logic [M_COUNT-1:0]                     ch_tlast,
  output logic [M_COUNT-1:0][ID_WIDTH-1:0]       ch_tid,
  output logic [M_COUNT-1:0][DEST_WIDTH-1:0]     ch_tdest,
  output logic [M_COUNT-1:0][USER_WIDTH-1:0]     ch_tuser,
  // port table
  input  logic [M_COUNT-1:0][UDP_PORT_WIDTH-1:0] match_port,
  input  logic [M_COUNT-1:0]                     match_enable,
  // drop statistics
  output logic                                   drop_pulse,
  output logic [15:0]                            drop_count
);

  if (M_COUNT < 1) begin : g_bad_count
    $error("udp_port_demux: M_COUNT must be at least 1");
  end
  if (KEEP_WIDTH * 8 < DATA_WIDTH) begin : g_bad_keep
    $error("udp_port_demux: KEEP_WIDTH too narrow for DATA_WIDTH");
  end

  demux_state_t         state;
  udp_hdr_t             hdr_q;
  logic [M_COUNT-1:0]   hdr_valid_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 hdr_ready_q;
  logic                 hdr_done;
  logic                 pay_done;
  logic [15:0]          drop_count_q;

  logic                 hit;
  logic [SEL_WIDTH-1:0] hit_index;
  logic [SEL_WIDTH-1:0] sel;
  logic                 hdr_fire;
  logic                 pay_fire;
  logic                 hdr_done_now;
  logic                 pay_done_now;

  udp_port_match #(
    .M_COUNT   (M_COUNT),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_match (
    .dest_port    (rx_hdr.dest_port),
    .match_port   (match_port),
    .match_enable (match_enable),
    .hit          (hit),
    .index        (hit_index)
  );

  // A single channel never needs a stored selection.
  assign sel = (M_COUNT == 1) ? '0 : sel_q;

  // Completion events of the current cycle, folded with those already seen.
  always_comb begin
    hdr_fire     = |(hdr_valid_q & ch_hdr_ready);
    pay_fire     = (state == FORWARD) && rx_tvalid && rx_tready && rx_tlast;
    hdr_done_now = hdr_done | hdr_fire;
    pay_done_now = pay_done | pay_fire;
  end

  assign rx_hdr_ready = hdr_ready_q;
  assign rx_tready    = (state == DROP)    ? 1'b1 :
                        (state == FORWARD) ? ch_tready[sel] : 1'b0;
  assign drop_pulse   = (state == DROP) && rx_tvalid && rx_tlast;
  assign drop_count   = drop_count_q;
  assign ch_hdr_valid = hdr_valid_q;

  for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_chan
    assign ch_hdr[gi]    = hdr_q;
    assign ch_tvalid[gi] = (state == FORWARD) && (sel == SEL_WIDTH'(gi)) && rx_tvalid;
    assign ch_tdata[gi]  = rx_tdata;
    assign ch_tkeep[gi]  = rx_tkeep;
    assign ch_tlast[gi]  = rx_tlast;
    assign ch_tid[gi]    = rx_tid;
    assign ch_tdest[gi]  = rx_tdest;
    assign ch_tuser[gi]  = rx_tuser;
  end

  // Packet FSM: header capture and routing, handoff tracking, drop counting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hdr_q        <= '0;
      hdr_valid_q  <= '0;
      sel_q        <= '0;
      hdr_ready_q  <= 1'b0;
      hdr_done     <= 1'b0;
      pay_done     <= 1'b0;
      drop_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          hdr_ready_q <= 1'b1;
          if (rx_hdr_valid && hdr_ready_q) begin
            hdr_q       <= rx_hdr;
            hdr_ready_q <= 1'b0;
            if (hit) begin
              sel_q       <= hit_index;
              hdr_valid_q <= M_COUNT'(1) << hit_index;
              state       <= FORWARD;
            end else begin
              state <= DROP;
            end
          end
        end
        FORWARD: begin
          if (hdr_fire) begin
            hdr_valid_q <= '0;
            hdr_done    <= 1'b1;
          end
          if (pay_fire) pay_done <= 1'b1;
          if (hdr_done_now && pay_done_now) begin
            hdr_done    <= 1'b0;
            pay_done    <= 1'b0;
            hdr_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        DROP: begin
          if (rx_tvalid && rx_tlast) begin
            drop_count_q <= drop_count_q + 16'd1;
            hdr_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_port_demux.sv
// Directed bench for udp_port_demux: routing, priority, drops, header hold,
// random backpressure and asynchronous reset mid-packet.
module tb_udp_port_demux;
  import udp_demux_pkg::*;

  localparam int M = 2;

  logic              clk;
  logic              reset_n;
  logic              rx_hdr_valid;
  logic              rx_hdr_ready;
  udp_hdr_t          rx_hdr;
  logic [7:0]        rx_tdata;
  logic [0:0]        rx_tkeep;
  logic              rx_tvalid;
  logic              rx_tready;
  logic              rx_tlast;
  logic [7:0]        rx_tid;
  logic [7:0]        rx_tdest;
  logic [0:0]        rx_tuser;
  logic [M-1:0]      ch_hdr_valid;
  logic [M-1:0]      ch_hdr_ready;
  udp_hdr_t [M-1:0]  ch_hdr;
  logic [M-1:0][7:0] ch_tdata;
  logic [M-1:0][0:0] ch_tkeep;
  logic [M-1:0]      ch_tvalid;
  logic [M-1:0]      ch_tready;
  logic [M-1:0]      ch_tlast;
  logic [M-1:0][7:0] ch_tid;
  logic [M-1:0][7:0] ch_tdest;
  logic [M-1:0][0:0] ch_tuser;
  logic [M-1:0][15:0] match_port;
  logic [M-1:0]      match_enable;
  logic              drop_pulse;
  logic [15:0]       drop_count;

  int n_vec  = 0;
  int n_miss = 0;
  int drop_exp = 0;
  int pkt_no = 0;

  udp_port_demux #(
    .M_COUNT    (M),
    .DATA_WIDTH (8),
    .KEEP_WIDTH (1),
    .ID_WIDTH   (8),
    .DEST_WIDTH (8),
    .USER_WIDTH (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_hdr_valid (rx_hdr_valid),
    .rx_hdr_ready (rx_hdr_ready),
    .rx_hdr       (rx_hdr),
    .rx_tdata     (rx_tdata),
    .rx_tkeep     (rx_tkeep),
    .rx_tvalid    (rx_tvalid),
    .rx_tready    (rx_tready),
    .rx_tlast     (rx_tlast),
    .rx_tid       (rx_tid),
    .rx_tdest     (rx_tdest),
    .rx_tuser     (rx_tuser),
    .ch_hdr_valid (ch_hdr_valid),
    .ch_hdr_ready (ch_hdr_ready),
    .ch_hdr       (ch_hdr),
    .ch_tdata     (ch_tdata),
    .ch_tkeep     (ch_tkeep),
    .ch_tvalid    (ch_tvalid),
    .ch_tready    (ch_tready),
    .ch_tlast     (ch_tlast),
    .ch_tid       (ch_tid),
    .ch_tdest     (ch_tdest),
    .ch_tuser     (ch_tuser),
    .match_port   (match_port),
    .match_enable (match_enable),
    .drop_pulse   (drop_pulse),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference routing: lowest enabled entry whose port equals dest wins.
  function automatic int route(input logic [15:0] d);
    for (int i = 0; i < M; i++) begin
      if (match_enable[i] && match_port[i] == d) return i;
    end
    return -1;
  endfunction

  function automatic udp_hdr_t mk_hdr(input logic [15:0] d, input logic [7:0] s);
    udp_hdr_t h;
    h.ip_source_ip = {24'h0a0000, s};
    h.ip_dest_ip   = 32'hc0a80001;
    h.source_port  = {8'h40, s};
    h.dest_port    = d;
    h.length       = 16'd8 + 16'(s);
    h.checksum     = {s, 8'h5a};
    return h;
  endfunction

  // One packet; starts and ends just after a rising edge.
  task automatic send_pkt(input logic [15:0] dport, input int nbeats, input int hold, input bit rbp);
    int         exp_ch;
    int         cyc;
    int         b;
    int         w;
    bit         hdone;
    bit         last;
    logic [M-1:0] onehot;
    logic [7:0] seed;
    udp_hdr_t   eh;
    logic [26:0] exp_beat;
    exp_ch = route(dport);
    seed   = 8'(pkt_no);
    pkt_no++;
    onehot = (exp_ch >= 0) ? M'(1 << exp_ch) : '0;
    hdone  = (exp_ch < 0);
    eh     = mk_hdr(dport, seed);
    ch_hdr_ready = '1;
    ch_tready    = '1;
    rx_tvalid    = 1'b0;
    rx_hdr       = eh;
    rx_hdr_valid = 1'b1;
    w = 0;
    while (!rx_hdr_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("hdr_accept_wait", 64'(w < 20), 64'd1);
    @(posedge clk); #1;
    rx_hdr_valid = 1'b0;
    rx_hdr       = '0;
    cyc = 0;
    b   = 0;
    while (!(b == nbeats && hdone) && cyc < 100) begin
      ch_hdr_ready = (cyc >= hold) ? '1 : '0;
      ch_tready    = rbp ? {1'b1, 1'($urandom_range(0, 1))} : '1;
      last = (b == nbeats - 1);
      if (b < nbeats) begin
        rx_tvalid = 1'b1;
        rx_tdata  = 8'(seed * 16 + b);
        rx_tkeep  = 1'b1;
        rx_tlast  = last;
        rx_tid    = seed;
        rx_tdest  = 8'(b);
        rx_tuser  = 1'(b ^ seed);
      end else begin
        rx_tvalid = 1'b0;
      end
      #4;
      if (!hdone) begin
        chk("hdr_valid", 64'(ch_hdr_valid), 64'(onehot));
        chk("hdr_fields", 64'({ch_hdr[exp_ch].dest_port, ch_hdr[exp_ch].source_port,
                               ch_hdr[exp_ch].length, ch_hdr[exp_ch].checksum}),
            64'({eh.dest_port, eh.source_port, eh.length, eh.checksum}));
        if (ch_hdr_ready[exp_ch]) hdone = 1'b1;
      end else begin
        chk("hdr_valid_low", 64'(ch_hdr_valid), 64'd0);
      end
      if (b < nbeats) begin
        chk("rx_tready", 64'(rx_tready), (exp_ch < 0) ? 64'd1 : 64'(ch_tready[exp_ch]));
        chk("ch_tvalid", 64'(ch_tvalid), 64'(onehot));
        chk("drop_pulse", 64'(drop_pulse), 64'((exp_ch < 0) && last));
        if (exp_ch >= 0) begin
          exp_beat = {1'(b ^ seed), last, seed, 8'(b), 1'b1, 8'(seed * 16 + b)};
          chk("ch_beat", 64'({ch_tuser[exp_ch], ch_tlast[exp_ch], ch_tid[exp_ch],
                             ch_tdest[exp_ch], ch_tkeep[exp_ch], ch_tdata[exp_ch]}),
              64'(exp_beat));
        end
        if ((exp_ch < 0) || ch_tready[exp_ch]) b++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("pkt_done_wait", 64'(cyc < 100), 64'd1);
    rx_tvalid = 1'b0;
    if (exp_ch < 0) drop_exp++;
    #1;
    chk("post_hdr_ready", 64'(rx_hdr_ready), 64'd1);
    chk("post_tready", 64'(rx_tready), 64'd0);
    chk("post_drop_count", 64'(drop_count), 64'(16'(drop_exp)));
    $display("pkt %0d dport=%0d beats=%0d ch=%0d cycles=%0d", pkt_no - 1, dport, nbeats, exp_ch, cyc);
  endtask

  initial begin
    int w;
    logic [15:0] d;
    reset_n      = 1'b0;
    rx_hdr_valid = 1'b0;
    rx_hdr       = '0;
    rx_tdata     = '0;
    rx_tkeep     = '0;
    rx_tvalid    = 1'b0;
    rx_tlast     = 1'b0;
    rx_tid       = '0;
    rx_tdest     = '0;
    rx_tuser     = '0;
    ch_hdr_ready = '1;
    ch_tready    = '1;
    match_port   = {16'd6000, 16'd5000};
    match_enable = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hdr_ready", 64'(rx_hdr_ready), 64'd0);
    chk("rst_tready", 64'(rx_tready), 64'd0);
    chk("rst_hdr_valid", 64'(ch_hdr_valid), 64'd0);
    chk("rst_hdr_fields", 64'(ch_hdr[0].dest_port), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_hdr_ready", 64'(rx_hdr_ready), 64'd1);

    // basic routing to ch1
    send_pkt(16'd6000, 4, 0, 1'b0);
    // priority: both entries equal, lowest wins; then ch0 disabled
    match_port = {16'd7000, 16'd7000};
    send_pkt(16'd7000, 2, 0, 1'b0);
    match_enable = 2'b10;
    send_pkt(16'd7000, 2, 0, 1'b0);
    match_port   = {16'd6000, 16'd5000};
    match_enable = 2'b11;
    // unmatched packet is dropped
    send_pkt(16'd1234, 3, 0, 1'b0);
    // header handoff held off while the payload completes
    send_pkt(16'd6000, 3, 5, 1'b0);
    // single-beat packet: header handoff and tlast in the same cycle
    send_pkt(16'd5000, 1, 0, 1'b0);
    // random traffic with ch0 backpressure
    for (int p = 0; p < 64; p++) begin
      case ($urandom_range(0, 3))
        0: d = 16'd5000;
        1: d = 16'd6000;
        2: d = 16'd7000;
        default: d = 16'd1234;
      endcase
      send_pkt(d, int'($urandom_range(1, 5)), 0, 1'b1);
    end

    // reset asserted while beat 2 of 4 is presented on ch0
    ch_hdr_ready = '0;
    ch_tready    = '1;
    rx_hdr       = mk_hdr(16'd5000, 8'hee);
    rx_hdr_valid = 1'b1;
    w = 0;
    while (!rx_hdr_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("mid_accept_wait", 64'(w < 20), 64'd1);
    @(posedge clk); #1;
    rx_hdr_valid = 1'b0;
    rx_tvalid    = 1'b1;
    rx_tdata     = 8'h01;
    rx_tlast     = 1'b0;
    @(posedge clk); #1;
    rx_tdata = 8'h02;
    #1;
    chk("mid_hdr_valid", 64'(ch_hdr_valid), 64'd1);
    chk("mid_tvalid", 64'(ch_tvalid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_hdr_valid", 64'(ch_hdr_valid), 64'd0);
    chk("arst_tvalid", 64'(ch_tvalid), 64'd0);
    chk("arst_tready", 64'(rx_tready), 64'd0);
    chk("arst_hdr_ready", 64'(rx_hdr_ready), 64'd0);
    chk("arst_drop_count", 64'(drop_count), 64'd0);
    rx_tvalid = 1'b0;
    drop_exp  = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arel_hdr_ready", 64'(rx_hdr_ready), 64'd1);
    send_pkt(16'd5000, 2, 0, 1'b0);
    send_pkt(16'd6000, 2, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/udp_port_demux.md
# udp_port_demux

Receive-side counterpart of the UDP transmit mux. It takes the single UDP RX header and payload stream from the UDP stack and steers each whole packet to one of `M_COUNT` application sinks. The sink is chosen by matching the UDP destination port against a runtime port table; packets with no match are consumed and counted. It sits between the UDP RX output of the IP/UDP stack and per-application RX handlers.

## Interface
- `M_COUNT`, default 2: number of output channels, ≥1.
- `SEL_WIDTH`, default `M_COUNT>1 ? $clog2(M_COUNT) : 1`: width of the channel index. Derived; do not override.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `udp_rx_header_if_sink`  UDP_RX_HEADER_IF.Sink  —  incoming header: `hdr_valid`/`hdr_ready`, ip_*, source_port, dest_port, length, checksum.
- `udp_rx_payload_if_sink`  AXIS_IF.Slave  —  incoming payload.
- `udp_rx_header_if_source[M_COUNT]`  UDP_RX_HEADER_IF.Source  —  per-channel header out.
- `udp_rx_payload_if_source[M_COUNT]`  AXIS_IF.Master  —  per-channel payload out. AXIS parameters must equal the sink's; mismatches are reported by elaboration-time `$error` assertions.
- `match_port[M_COUNT]`  in  16 each  destination port for each channel.
- `match_enable`  in  M_COUNT  per-channel enable for table entries.
- `drop_pulse`  out  1  one-cycle strobe when a dropped packet's tlast is consumed.
- `drop_count`  out  16  count of dropped packets, wraps modulo 2^16.

## Operation
- States (enum in package): `IDLE`, `FORWARD`, `DROP`.
- **IDLE**
  - Sink `hdr_ready`=1 and sink `tready`=0.
  - On `hdr_valid && hdr_ready`, all header fields are registered.
  - The port table is evaluated against `dest_port`: hit where `match_enable[i] && match_port[i]==dest_port`. The lowest index wins (priority).
  - On a hit, `sel_q` ← index and the next state is `FORWARD`. On no hit, the next state is `DROP`.
- **FORWARD**
  - `source[sel_q].hdr_valid`=1 with the registered fields, held stable until `hdr_ready`. Then it drops to 0 and `hdr_done` is set.
  - Payload is combinational pass-through to `sel_q`, beginning the same cycle `FORWARD` is entered:
    - tvalid and all sidebands go to channel `sel_q`.
    - Sink tready = `source[sel_q].tready`.
    - Non-selected channels see tvalid=0 and hdr_valid=0.
  - `pay_done` is set on the beat with `tvalid && tready && tlast`.
  - Exit to `IDLE` in the cycle both flags are true, counting the current cycle's events. Both flags are cleared on exit.
- **DROP**: sink tready=1 and all beats are discarded. On the tlast beat: `drop_pulse`=1, `drop_count`++, next state `IDLE`.
- The port table is sampled only at header acceptance. Table changes mid-packet do not affect the packet in flight.
- Exactly one header per packet. Every packet carries at least one payload beat ending in tlast.
- Data, tkeep, tid, tdest and tuser pass unmodified, including tuser on tlast.

## Timing
- Header latency: accepted at edge N, `hdr_valid` asserted on channel outputs from cycle N+1.
- Payload latency: 0 cycles (combinational) while in `FORWARD`. No payload buffering.
- Inter-packet gap: at least one cycle in `IDLE` between tlast and the next header acceptance.
- Handshake rules: valid never depends on ready. Once asserted, `hdr_valid` stays high with stable fields until accepted.
- Reset values:
  - state=`IDLE`.
  - Sink `hdr_ready` is registered: 0 during reset, 1 from the first edge after release.
  - All source `hdr_valid`=0 and registered header fields=0.
  - Sink tready=0, `drop_pulse`=0, `drop_count`=0, `hdr_done`=`pay_done`=0.
- Reset mid-packet: immediate return to `IDLE`, with the partially forwarded packet truncated. Stale payload beats without a header stall at the sink; upstream is reset by the same `reset_n`.
- Simultaneous events: header handoff and tlast in the same cycle exit `FORWARD` that cycle.
- `drop_count` wraps from 0xFFFF to 0x0000.
- `M_COUNT`=1: `SEL_WIDTH`=1, `sel_q` is tied to 0, and matching still gates drops.

## Structure
- Package `udp_demux_pkg`: the `demux_state_t` enum and a `UDP_PORT_WIDTH`=16 constant.
- Sub-module `udp_port_match`: combinational priority match over `match_port`/`match_enable`, outputs `hit` and `index[SEL_WIDTH]`.
- Top level holds the FSM, header register, payload routing and drop counter.

## Test plan
- Port 5000 on ch0, 6000 on ch1, header `dest_port`=6000 with a 4-beat payload → ch1 header at N+1, 4 beats on ch1, ch0 silent, `drop_count`=0.
- Both entries=7000, header 7000 → routed to ch0 (priority). Then `match_enable`=2'b10 and header 7000 → routed to ch1.
- Header `dest_port`=1234 with no match, 3-beat payload → sink tready=1 for 3 beats, single `drop_pulse`, `drop_count`=1, no source valid.
- ch1 `hdr_ready` held low 5 cycles while payload beats are accepted → `hdr_valid` stable 5 cycles, FSM leaves `FORWARD` only after both handoffs, next header accepted ≥1 cycle later.
- Random tready backpressure on ch0, 64 back-to-back packets with random ports → every beat and tuser delivered in order to the correct channel; drop count equals the number of unmatched packets.
- Assert `reset_n` low on beat 2 of 4 → all outputs return to reset values asynchronously. After release, `hdr_ready`=1 one edge later and the next packet routes correctly.
